// File: rtl/jtag_emu_seq_if.sv
// Command/response handshake between the PS register bank and the JTAG TAP sequencer.
// The master side issues scan commands and the slave side (the sequencer) returns TDO.
interface jtag_emu_seq_if;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_trst_i;
   logic [4:0]  cmd_len_i;
   logic [31:0] cmd_tms_i;
   logic [31:0] cmd_tdi_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_tdo_o;
   logic        busy_o;

   modport master (
      output cmd_valid_i, cmd_trst_i, cmd_len_i, cmd_tms_i, cmd_tdi_i, rsp_ready_i,
      input  cmd_ready_o, rsp_valid_o, rsp_tdo_o, busy_o
   );

   modport slave (
      input  cmd_valid_i, cmd_trst_i, cmd_len_i, cmd_tms_i, cmd_tdi_i, rsp_ready_i,
      output cmd_ready_o, rsp_valid_o, rsp_tdo_o, busy_o
   );
endinterface

// File: rtl/jtag_emu_seq.sv
// JTAG TAP sequencer: turns one scan command of up to 32 bits into TCK/TMS/TDI/TRSTn
// waveforms for the PULPino debug port and returns the TDO bits captured on rising TCK.
module jtag_emu_seq #(
   parameter int unsigned HALF_PERIOD = 4
) (
   input  logic          clk,
   input  logic          rst,
   jtag_emu_seq_if.slave bus,
   output logic          tck_o,
   output logic          tms_o,
   output logic          tdi_o,
   output logic          trstn_o,
   input  logic          tdo_i
);
   localparam int unsigned   PW         = $clog2(HALF_PERIOD + 1);
   localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_PERIOD - 1);

   typedef enum logic [2:0] {StIdle, StLow, StHigh, StTrst, StDone} state_e;

   state_e        r_state, w_state_d;
   logic [PW-1:0] r_phase, w_phase_d;
   logic [4:0]    r_bits, w_bits_d;
   logic [4:0]    r_len, w_len_d;
   logic [31:0]   r_tms, w_tms_d;
   logic [31:0]   r_tdi, w_tdi_d;
   logic [31:0]   r_tdo, w_tdo_d;
   logic          r_tdo_in;
   logic          r_tck;
   logic          r_trstn;
   logic          w_phase_end;

   assign w_phase_end = (r_phase == '0);

   always_comb begin
      w_state_d = r_state;
      w_phase_d = r_phase;
      w_bits_d  = r_bits;
      w_len_d   = r_len;
      w_tms_d   = r_tms;
      w_tdi_d   = r_tdi;
      w_tdo_d   = r_tdo;
      unique case (r_state)
         StIdle: begin
            if (bus.cmd_valid_i) begin
               w_phase_d = PHASE_LAST;
               w_tdo_d   = '0;
               if (bus.cmd_trst_i) begin
                  // Reset pulse is two phase-counter periods long.
                  w_bits_d  = 5'd1;
                  w_state_d = StTrst;
               end else begin
                  w_tms_d   = bus.cmd_tms_i;
                  w_tdi_d   = bus.cmd_tdi_i;
                  w_bits_d  = bus.cmd_len_i;
                  w_len_d   = bus.cmd_len_i;
                  w_state_d = StLow;
               end
            end
         end
         StLow: begin
            if (w_phase_end) begin
               w_phase_d = PHASE_LAST;
               w_state_d = StHigh;
            end else begin
               w_phase_d = r_phase - 1'b1;
            end
         end
         StHigh: begin
            if (w_phase_end) begin
               w_tdo_d   = {r_tdo_in, r_tdo[31:1]};
               w_phase_d = PHASE_LAST;
               if (r_bits == 5'd0) begin
                  w_state_d = StDone;
               end else begin
                  w_bits_d  = r_bits - 5'd1;
                  w_tms_d   = {1'b0, r_tms[31:1]};
                  w_tdi_d   = {1'b0, r_tdi[31:1]};
                  w_state_d = StLow;
               end
            end else begin
               w_phase_d = r_phase - 1'b1;
            end
         end
         StTrst: begin
            if (w_phase_end) begin
               w_phase_d = PHASE_LAST;
               if (r_bits == 5'd0) begin
                  w_state_d = StDone;
               end else begin
                  w_bits_d = r_bits - 5'd1;
               end
            end else begin
               w_phase_d = r_phase - 1'b1;
            end
         end
         StDone: begin
            if (bus.rsp_ready_i) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= StIdle;
         r_phase  <= '0;
         r_bits   <= '0;
         r_len    <= '0;
         r_tms    <= 32'd1;
         r_tdi    <= '0;
         r_tdo    <= '0;
         r_tdo_in <= 1'b0;
         r_tck    <= 1'b0;
         r_trstn  <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_phase  <= w_phase_d;
         r_bits   <= w_bits_d;
         r_len    <= w_len_d;
         r_tms    <= w_tms_d;
         r_tdi    <= w_tdi_d;
         r_tdo    <= w_tdo_d;
         r_tdo_in <= tdo_i;
         // Pin drivers are registered from the next state so they change with the state.
         r_tck    <= (w_state_d == StHigh);
         r_trstn  <= (w_state_d != StTrst);
      end
   end

   assign tck_o   = r_tck;
   assign tms_o   = r_tms[0];
   assign tdi_o   = r_tdi[0];
   assign trstn_o = r_trstn;

   assign bus.cmd_ready_o = (r_state == StIdle);
   assign bus.busy_o      = (r_state != StIdle);
   assign bus.rsp_valid_o = (r_state == StDone);
   // TDO enters at the MSB; right-align so bit i is the sample from TCK cycle i.
   assign bus.rsp_tdo_o   = (r_state == StDone) ? (r_tdo >> (5'd31 - r_len)) : 32'd0;
endmodule

// File: tb/tb_jtag_emu_seq.sv
// Bench for jtag_emu_seq: two instances (HALF_PERIOD 2 and 4) driven by scenario tasks and
// checked against a scan-level model of the expected TDO, waveform counts and latency.
module tb_jtag_emu_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]       cmd_valid, cmd_trst, rsp_ready;
   logic [1:0][4:0]  cmd_len;
   logic [1:0][31:0] cmd_tms, cmd_tdi;
   logic [1:0]       cmd_ready, rsp_valid, busy, tck, tms, tdi, trstn, tdo;
   logic [1:0][31:0] rsp_tdo;

   int tests = 0;
   int fails = 0;
   logic prev0 = 1'b0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned HP = (g == 0) ? 2 : 4;
      jtag_emu_seq_if u_if ();
      assign u_if.cmd_valid_i = cmd_valid[g];
      assign u_if.cmd_trst_i  = cmd_trst[g];
      assign u_if.cmd_len_i   = cmd_len[g];
      assign u_if.cmd_tms_i   = cmd_tms[g];
      assign u_if.cmd_tdi_i   = cmd_tdi[g];
      assign u_if.rsp_ready_i = rsp_ready[g];
      assign cmd_ready[g]     = u_if.cmd_ready_o;
      assign rsp_valid[g]     = u_if.rsp_valid_o;
      assign rsp_tdo[g]       = u_if.rsp_tdo_o;
      assign busy[g]          = u_if.busy_o;
      jtag_emu_seq #(.HALF_PERIOD(HP)) u_dut (
         .clk     (clk),
         .rst     (rst),
         .bus     (u_if.slave),
         .tck_o   (tck[g]),
         .tms_o   (tms[g]),
         .tdi_o   (tdi[g]),
         .trstn_o (trstn[g]),
         .tdo_i   (tdo[g])
      );
   end

   // Instance 0: TAP modelled as a one-stage loopback (capture on rising TCK, drive on falling).
   logic cap0, tdo0;
   always @(posedge tck[0] or posedge rst) if (rst) cap0 <= 1'b0; else cap0 <= tdi[0];
   always @(negedge tck[0] or posedge rst) if (rst) tdo0 <= 1'b0; else tdo0 <= cap0;
   assign tdo[0] = tdo0;
   assign tdo[1] = tdi[1];

   function automatic logic [31:0] mask_n(input int n);
      logic [32:0] m;
      m = (33'd1 << n) - 33'd1;
      return m[31:0];
   endfunction

   // Instance 0 returns TDI delayed by one bit (first bit is the previous scan's last TDI).
   function automatic logic [31:0] exp_tdo(input int g, input logic [4:0] len,
                                           input logic [31:0] tdi_v, input logic prev);
      logic [31:0] v;
      v = (g == 1) ? tdi_v : {tdi_v[30:0], prev};
      return v & mask_n(int'(len) + 1);
   endfunction

   task automatic do_cmd(input int g, input bit trst_v, input logic [4:0] len,
                         input logic [31:0] tms_v, input logic [31:0] tdi_v,
                         output int lat, output int n_rise, output int n_hi, output int n_trst,
                         output int n_nbusy, output logic [31:0] tms_seq,
                         output logic [31:0] tdi_seq, output logic [31:0] tdo_v);
      bit acc;
      int waitc;
      logic prev_tck;
      cmd_valid[g] = 1'b1;
      cmd_trst[g]  = trst_v;
      cmd_len[g]   = len;
      cmd_tms[g]   = tms_v;
      cmd_tdi[g]   = tdi_v;
      waitc = 0;
      do begin
         acc = cmd_ready[g];
         @(posedge clk); #1;
         waitc++;
      end while (!acc && waitc < 100);
      // Scramble the fields after acceptance; they must have no further effect.
      cmd_valid[g] = 1'b0;
      cmd_trst[g]  = 1'($urandom);
      cmd_len[g]   = 5'($urandom);
      cmd_tms[g]   = $urandom;
      cmd_tdi[g]   = $urandom;
      lat = 0; n_rise = 0; n_hi = 0; n_trst = 0; n_nbusy = 0;
      tms_seq = '0; tdi_seq = '0; prev_tck = 1'b0;
      for (int c = 1; c < 400 && acc; c++) begin
         if (rsp_valid[g]) begin
            lat = c;
            break;
         end
         if (tck[g] && !prev_tck) begin
            if (n_rise < 32) begin
               tms_seq[n_rise] = tms[g];
               tdi_seq[n_rise] = tdi[g];
            end
            n_rise++;
         end
         n_hi    += int'(tck[g]);
         n_trst  += int'(!trstn[g]);
         n_nbusy += int'(!busy[g]);
         prev_tck = tck[g];
         @(posedge clk); #1;
      end
      tdo_v = rsp_tdo[g];
   endtask

   task automatic finish_rsp(input int g);
      rsp_ready[g] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[g] = 1'b0;
   endtask

   task automatic test_reset();
      cmd_valid = '1; cmd_trst = '0; rsp_ready = '0;
      cmd_len = '0; cmd_tms = '0; cmd_tdi = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         tests++;
         if ({cmd_ready[g], rsp_valid[g], busy[g], tck[g], tms[g], tdi[g], trstn[g]} !== 7'b1000100)
         begin
            fails++;
            $display("FAIL reset_outputs[%0d]: got rdy/vld/busy/tck/tms/tdi/trstn=%b want 1000100",
                     g, {cmd_ready[g], rsp_valid[g], busy[g], tck[g], tms[g], tdi[g], trstn[g]});
         end
         tests++;
         if (rsp_tdo[g] !== 32'd0) begin
            fails++;
            $display("FAIL reset_tdo[%0d]: got %h want 0", g, rsp_tdo[g]);
         end
      end
      cmd_valid = '0;
      rst = 1'b0;
      #1;
      tests++;
      if (trstn !== 2'b00) begin
         fails++;
         $display("FAIL reset_trstn_hold: got %b want 00", trstn);
      end
      @(posedge clk); #1;
      tests++;
      if ({trstn, cmd_ready, busy} !== 6'b111100) begin
         fails++;
         $display("FAIL reset_release: got trstn/rdy/busy=%b want 111100", {trstn, cmd_ready, busy});
      end
   endtask

   task automatic test_shift8();
      int lat, nr, nh, nt, nb;
      logic [31:0] ms, ds, dv, ev;
      ev = exp_tdo(0, 5'd7, 32'hA5, prev0);
      do_cmd(0, 1'b0, 5'd7, 32'h0, 32'hA5, lat, nr, nh, nt, nb, ms, ds, dv);
      tests++;
      if (lat !== 33) begin fails++; $display("FAIL shift8_latency: got %0d want 33", lat); end
      tests++;
      if (nr !== 8 || nh !== 16) begin
         fails++;
         $display("FAIL shift8_tck: got rises=%0d high=%0d want 8/16", nr, nh);
      end
      tests++;
      if (ds[7:0] !== 8'hA5) begin fails++; $display("FAIL shift8_tdi_seq: got %h want a5", ds[7:0]); end
      tests++;
      if (dv !== ev) begin fails++; $display("FAIL shift8_tdo: got %h want %h", dv, ev); end
      prev0 = 1'b1;
      finish_rsp(0);
   endtask

   task automatic test_shift32();
      int lat, nr, nh, nt, nb;
      logic [31:0] ms, ds, dv, tv;
      tv = $urandom;
      do_cmd(1, 1'b0, 5'd31, tv, 32'hDEADBEEF, lat, nr, nh, nt, nb, ms, ds, dv);
      tests++;
      if (lat !== 257) begin fails++; $display("FAIL shift32_latency: got %0d want 257", lat); end
      tests++;
      if (dv !== 32'hDEADBEEF) begin fails++; $display("FAIL shift32_tdo: got %h want deadbeef", dv); end
      tests++;
      if (nb !== 0 || nr !== 32 || nh !== 128) begin
         fails++;
         $display("FAIL shift32_wave: got not_busy=%0d rises=%0d high=%0d want 0/32/128", nb, nr, nh);
      end
      tests++;
      if (ms !== tv) begin fails++; $display("FAIL shift32_tms_seq: got %h want %h", ms, tv); end
      finish_rsp(1);
      tests++;
      if (busy[1] !== 1'b0) begin fails++; $display("FAIL shift32_idle: got busy=%b want 0", busy[1]); end
   endtask

   task automatic test_trst();
      int lat, nr, nh, nt, nb;
      logic [31:0] ms, ds, dv;
      do_cmd(1, 1'b1, 5'($urandom), $urandom, $urandom, lat, nr, nh, nt, nb, ms, ds, dv);
      tests++;
      if (lat !== 9 || nt !== 8 || nr !== 0) begin
         fails++;
         $display("FAIL trst_wave: got lat=%0d trst_low=%0d rises=%0d want 9/8/0", lat, nt, nr);
      end
      tests++;
      if (dv !== 32'd0 || trstn[1] !== 1'b1) begin
         fails++;
         $display("FAIL trst_rsp: got tdo=%h trstn=%b want 0/1", dv, trstn[1]);
      end
      finish_rsp(1);
      do_cmd(1, 1'b0, 5'd4, 32'h1F, $urandom, lat, nr, nh, nt, nb, ms, ds, dv);
      tests++;
      if (ms[4:0] !== 5'h1F || lat !== 41) begin
         fails++;
         $display("FAIL idcode_tms_seq: got tms=%h lat=%0d want 1f/41", ms[4:0], lat);
      end
      finish_rsp(1);
      tests++;
      if (tms[1] !== 1'b1) begin fails++; $display("FAIL idcode_tms_hold: got %b want 1", tms[1]); end
   endtask

   task automatic test_backpressure();
      int lat, nr, nh, nt, nb, viol;
      logic [31:0] ms, ds, dv, snap, ev, tdi1, tdi2;
      logic [4:0] len1, len2;
      len1 = 5'($urandom); tdi1 = $urandom;
      len2 = 5'($urandom); tdi2 = $urandom;
      ev = exp_tdo(0, len1, tdi1, prev0);
      do_cmd(0, 1'b0, len1, $urandom, tdi1, lat, nr, nh, nt, nb, ms, ds, dv);
      snap = rsp_tdo[0];
      tests++;
      if (snap !== ev) begin fails++; $display("FAIL bp_first_tdo: got %h want %h", snap, ev); end
      prev0 = tdi1[len1];
      cmd_valid[0] = 1'b1; cmd_trst[0] = 1'b0; cmd_len[0] = len2;
      cmd_tms[0] = $urandom; cmd_tdi[0] = tdi2;
      viol = 0;
      for (int c = 0; c < 20; c++) begin
         if (rsp_valid[0] !== 1'b1 || rsp_tdo[0] !== snap || cmd_ready[0] !== 1'b0 || busy[0] !== 1'b1)
            viol++;
         @(posedge clk); #1;
      end
      tests++;
      if (viol !== 0) begin fails++; $display("FAIL bp_hold: got %0d bad cycles want 0", viol); end
      finish_rsp(0);
      tests++;
      if (cmd_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
         fails++;
         $display("FAIL bp_release: got rdy=%b vld=%b want 1/0", cmd_ready[0], rsp_valid[0]);
      end
      ev = exp_tdo(0, len2, tdi2, prev0);
      do_cmd(0, 1'b0, len2, cmd_tms[0], tdi2, lat, nr, nh, nt, nb, ms, ds, dv);
      tests++;
      if (lat !== 4 * (int'(len2) + 1) + 1 || dv !== ev) begin
         fails++;
         $display("FAIL bp_second: got lat=%0d tdo=%h want %0d/%h", lat, dv, 4 * (int'(len2) + 1) + 1, ev);
      end
      prev0 = tdi2[len2];
      finish_rsp(0);
   endtask

   task automatic test_mid_reset();
      int lat, nr, nh, nt, nb, rises;
      logic [31:0] ms, ds, dv, tv;
      logic prev_tck;
      cmd_valid[1] = 1'b1; cmd_trst[1] = 1'b0; cmd_len[1] = 5'd7;
      cmd_tms[1] = $urandom; cmd_tdi[1] = $urandom;
      @(posedge clk); #1;
      cmd_valid[1] = 1'b0;
      rises = 0; prev_tck = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (tck[1] && !prev_tck) rises++;
         if (rises == 4) break;
         prev_tck = tck[1];
         @(posedge clk); #1;
      end
      tests++;
      if (rises !== 4) begin fails++; $display("FAIL midrst_reach: got %0d rises want 4", rises); end
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({tck[1], trstn[1], busy[1], rsp_valid[1]} !== 4'b0000) begin
         fails++;
         $display("FAIL midrst_force: got tck/trstn/busy/vld=%b want 0000",
                  {tck[1], trstn[1], busy[1], rsp_valid[1]});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      prev0 = 1'b0;
      @(posedge clk); #1;
      tv = $urandom;
      do_cmd(1, 1'b0, 5'd0, $urandom, tv, lat, nr, nh, nt, nb, ms, ds, dv);
      tests++;
      if (lat !== 9 || dv !== {31'd0, tv[0]}) begin
         fails++;
         $display("FAIL midrst_after: got lat=%0d tdo=%h want 9/%h", lat, dv, {31'd0, tv[0]});
      end
      finish_rsp(1);
   endtask

   task automatic test_random();
      int lat, nr, nh, nt, nb, g, hp, n, elat;
      logic [31:0] ms, ds, dv, ev, tmsv, tdiv;
      logic [4:0] len;
      bit tr;
      for (int i = 0; i < 16; i++) begin
         g = int'($urandom_range(0, 1));
         hp = (g == 0) ? 2 : 4;
         tr = ($urandom_range(0, 5) == 0);
         len = 5'($urandom); tmsv = $urandom; tdiv = $urandom;
         n = int'(len) + 1;
         ev = tr ? 32'd0 : exp_tdo(g, len, tdiv, prev0);
         elat = tr ? 2 * hp + 1 : 2 * hp * n + 1;
         do_cmd(g, tr, len, tmsv, tdiv, lat, nr, nh, nt, nb, ms, ds, dv);
         tests++;
         if (lat !== elat || nr !== (tr ? 0 : n) || nt !== (tr ? 2 * hp : 0)) begin
            fails++;
            $display("FAIL rand_wave[%0d]: got lat=%0d rises=%0d trst_low=%0d want %0d/%0d/%0d",
                     i, lat, nr, nt, elat, tr ? 0 : n, tr ? 2 * hp : 0);
         end
         tests++;
         if (dv !== ev) begin fails++; $display("FAIL rand_tdo[%0d]: got %h want %h", i, dv, ev); end
         tests++;
         if (!tr && ((ds ^ tdiv) & mask_n(n)) !== 32'd0) begin
            fails++;
            $display("FAIL rand_tdi_seq[%0d]: got %h want %h", i, ds & mask_n(n), tdiv & mask_n(n));
         end
         if (g == 0 && !tr) prev0 = tdiv[len];
         finish_rsp(g);
      end
   endtask

   initial begin
      test_reset();
      test_shift8();
      test_shift32();
      test_trst();
      test_backpressure();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
